// File: rtl/spart_rx_if.sv
// ---------------------------------------------------------------------------
// spart_rx_if -- bus-side signal bundle of the SPART receiver.
//
// Groups the receive-buffer read strobe and the buffer/status outputs that
// the bus decode block consumes.
//   rx_read     : one-clk pulse, bus decode -> receiver, consumes the buffer
//   rx_data     : last received byte
//   rda         : receive data available
//   framing_err : stop bit of the last byte sampled low
//   overrun     : a byte completed while rda was already set
//   rx_busy     : receiver FSM is not idle
//
// Modports:
//   master : bus decode side (drives rx_read, observes status)
//   slave  : receiver side (observes rx_read, drives status)
// ---------------------------------------------------------------------------
interface spart_rx_if #(
    parameter int DATA_BITS = 8
);
    logic                 rx_read;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rda;
    logic                 framing_err;
    logic                 overrun;
    logic                 rx_busy;

    modport master (
        output rx_read,
        input  rx_data,
        input  rda,
        input  framing_err,
        input  overrun,
        input  rx_busy
    );

    modport slave (
        input  rx_read,
        output rx_data,
        output rda,
        output framing_err,
        output overrun,
        output rx_busy
    );
endinterface

// File: rtl/spart_rx.sv
// ---------------------------------------------------------------------------
// spart_rx -- receive half of the SPART.
//
// Deserialises an 8N1 asynchronous frame arriving on RxD into a byte, using
// the rxEnable oversample tick from the baud generator, and holds the byte
// plus status flags until the bus side reads the receive buffer.
//
// Ports:
//   clk      : system clock, all state changes on the rising edge
//   rst      : synchronous, active-high reset
//   rxEnable : one-clk pulse at OVERSAMPLE x baud rate
//   RxD      : asynchronous serial input, idle high
//   bus      : spart_rx_if.slave (rx_read in; rx_data, rda, framing_err,
//              overrun, rx_busy out)
//
// Parameters:
//   OVERSAMPLE : rxEnable ticks per bit period (even, >= 4)
//   DATA_BITS  : data bits per frame, LSB first
// ---------------------------------------------------------------------------
module spart_rx #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         rxEnable,
    input  logic         RxD,
    spart_rx_if.slave    bus
);

    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = $clog2(DATA_BITS + 1);

    // Start-bit centre is half a bit after the detecting tick; data and stop
    // samples are then a full bit period apart.
    localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] FULL_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t               state_reg;
    logic [1:0]           sync_reg;
    logic [DATA_BITS-1:0] shift_reg;
    logic [TICK_W-1:0]    tick_cnt_reg;
    logic [BIT_W-1:0]     bit_cnt_reg;
    logic [DATA_BITS-1:0] rx_data_reg;
    logic                 rda_reg;
    logic                 framing_err_reg;
    logic                 overrun_reg;
    logic                 rx_busy_reg;
    logic                 rxd_s;

    // Two-flop synchroniser; everything downstream samples rxd_s only.
    assign rxd_s = sync_reg[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            sync_reg        <= '1;
            shift_reg       <= '1;
            tick_cnt_reg    <= '0;
            bit_cnt_reg     <= '0;
            rx_data_reg     <= '0;
            rda_reg         <= 1'b0;
            framing_err_reg <= 1'b0;
            overrun_reg     <= 1'b0;
            rx_busy_reg     <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[0], RxD};

            // A read consumes the buffer. A completion on the same edge is
            // assigned further down and therefore takes precedence.
            if (bus.rx_read && rda_reg) begin
                rda_reg         <= 1'b0;
                overrun_reg     <= 1'b0;
                framing_err_reg <= 1'b0;
            end

            if (rxEnable) begin
                unique case (state_reg)
                    IDLE: begin
                        if (!rxd_s) begin
                            state_reg    <= START;
                            rx_busy_reg  <= 1'b1;
                            tick_cnt_reg <= '0;
                        end
                    end

                    START: begin
                        if (tick_cnt_reg == HALF_LAST) begin
                            if (!rxd_s) begin
                                state_reg    <= DATA;
                                tick_cnt_reg <= '0;
                                bit_cnt_reg  <= '0;
                            end else begin
                                // Line went high again before mid-start-bit:
                                // a glitch, not a frame.
                                state_reg   <= IDLE;
                                rx_busy_reg <= 1'b0;
                            end
                        end else begin
                            tick_cnt_reg <= tick_cnt_reg + 1'b1;
                        end
                    end

                    DATA: begin
                        if (tick_cnt_reg == FULL_LAST) begin
                            // Shift right so the first (LSB) bit ends at bit 0.
                            shift_reg    <= {rxd_s, shift_reg[DATA_BITS-1:1]};
                            tick_cnt_reg <= '0;
                            bit_cnt_reg  <= bit_cnt_reg + 1'b1;
                            if (bit_cnt_reg == BIT_LAST) begin
                                state_reg <= STOP;
                            end
                        end else begin
                            tick_cnt_reg <= tick_cnt_reg + 1'b1;
                        end
                    end

                    STOP: begin
                        if (tick_cnt_reg == FULL_LAST) begin
                            // Leave at mid-stop-bit so a following start
                            // edge is not missed.
                            state_reg       <= IDLE;
                            rx_busy_reg     <= 1'b0;
                            tick_cnt_reg    <= '0;
                            rx_data_reg     <= shift_reg;
                            rda_reg         <= 1'b1;
                            framing_err_reg <= ~rxd_s;
                            overrun_reg     <= rda_reg & ~bus.rx_read;
                        end else begin
                            tick_cnt_reg <= tick_cnt_reg + 1'b1;
                        end
                    end

                    default: begin
                        state_reg   <= IDLE;
                        rx_busy_reg <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.rx_data     = rx_data_reg;
    assign bus.rda         = rda_reg;
    assign bus.framing_err = framing_err_reg;
    assign bus.overrun     = overrun_reg;
    assign bus.rx_busy     = rx_busy_reg;

endmodule

// File: tb/tb_spart_rx.sv
// ---------------------------------------------------------------------------
// tb_spart_rx -- directed self-checking bench for spart_rx.
// clk 10 ns, rxEnable every 10 clk, 16 ticks per bit -> 160 clk per bit.
// ---------------------------------------------------------------------------
module tb_spart_rx;

    localparam int BIT_CLK = 160;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rxEnable = 1'b0;
    logic RxD = 1'b1;

    spart_rx_if #(.DATA_BITS(8)) bus ();

    spart_rx #(
        .OVERSAMPLE(16),
        .DATA_BITS (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rxEnable (rxEnable),
        .RxD      (RxD),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    // Tick generator and cycle counter.
    logic [3:0] div = 4'd0;
    always @(negedge clk) begin
        div      <= (div == 4'd9) ? 4'd0 : div + 4'd1;
        rxEnable <= (div == 4'd9);
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_assert = 0;
    int n_fail   = 0;

    int busy_cyc;
    int rda_cyc;
    int start_cyc;
    int n;
    logic seen;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
        end
        $display("check %-16s observed=%0h expected=%0h", name, obs, exp);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        RxD = 1'b0;
        repeat (BIT_CLK) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RxD = b[i];
            repeat (BIT_CLK) @(negedge clk);
        end
        RxD = stop_bit;
        repeat (BIT_CLK) @(negedge clk);
        RxD = 1'b1;
    endtask

    task automatic read_pulse();
        bus.rx_read = 1'b1;
        @(negedge clk);
        bus.rx_read = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_busy(output int c);
        int k;
        k = 0;
        while (bus.rx_busy !== 1'b1 && k < 400) begin
            @(negedge clk);
            k++;
        end
        c = cyc;
        chk("busy_rise_bound", 32'(k < 400), 32'd1);
    endtask

    task automatic wait_rda(output int c);
        int k;
        k = 0;
        while (bus.rda !== 1'b1 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        c = cyc;
        chk("rda_rise_bound", 32'(k < 2000), 32'd1);
    endtask

    initial begin
        #900us;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.rx_read = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        chk("rst_rx_data", 32'(bus.rx_data), 32'h00);
        chk("rst_rda", 32'(bus.rda), 32'd0);
        chk("rst_fe", 32'(bus.framing_err), 32'd0);
        chk("rst_ov", 32'(bus.overrun), 32'd0);
        chk("rst_busy", 32'(bus.rx_busy), 32'd0);
        repeat (50) @(negedge clk);

        // Byte 0xA5 with timing: rda rises 8 + 9*16 ticks after detection,
        // i.e. 1520 clk after rx_busy rises, and 1523..1532 clk after the
        // start-bit falling edge (2 sync flops + tick phase).
        start_cyc = cyc;
        fork
            send_frame(8'hA5, 1'b1);
            begin
                wait_busy(busy_cyc);
                wait_rda(rda_cyc);
            end
        join
        chk("a5_rise_vs_busy", 32'(rda_cyc - busy_cyc), 32'd1520);
        chk("a5_rise_window", 32'((rda_cyc - start_cyc >= 1523) && (rda_cyc - start_cyc <= 1532)), 32'd1);
        chk("a5_data", 32'(bus.rx_data), 32'hA5);
        chk("a5_rda", 32'(bus.rda), 32'd1);
        chk("a5_fe", 32'(bus.framing_err), 32'd0);
        chk("a5_ov", 32'(bus.overrun), 32'd0);
        chk("a5_busy", 32'(bus.rx_busy), 32'd0);
        read_pulse();
        chk("a5_read_rda", 32'(bus.rda), 32'd0);
        repeat (100) @(negedge clk);

        // Glitch rejection: 4 ticks low, then high.
        RxD = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.rx_busy === 1'b1) seen = 1'b1;
        end
        RxD = 1'b1;
        chk("glitch_busy_pulse", 32'(seen), 32'd1);
        repeat (200) @(negedge clk);
        chk("glitch_busy_drop", 32'(bus.rx_busy), 32'd0);
        chk("glitch_rda", 32'(bus.rda), 32'd0);
        send_frame(8'h3C, 1'b1);
        repeat (20) @(negedge clk);
        chk("3c_data", 32'(bus.rx_data), 32'h3C);
        chk("3c_rda", 32'(bus.rda), 32'd1);
        chk("3c_fe", 32'(bus.framing_err), 32'd0);
        read_pulse();
        repeat (100) @(negedge clk);

        // Framing error: 0x81 with stop bit low.
        send_frame(8'h81, 1'b0);
        repeat (320) @(negedge clk);
        chk("fe_data", 32'(bus.rx_data), 32'h81);
        chk("fe_rda", 32'(bus.rda), 32'd1);
        chk("fe_flag", 32'(bus.framing_err), 32'd1);
        read_pulse();
        chk("fe_read_rda", 32'(bus.rda), 32'd0);
        chk("fe_read_fe", 32'(bus.framing_err), 32'd0);
        chk("fe_read_data", 32'(bus.rx_data), 32'h81);
        repeat (100) @(negedge clk);

        // Overrun: 0x11 then 0x22 back-to-back, no read.
        send_frame(8'h11, 1'b1);
        chk("ov1_rda", 32'(bus.rda), 32'd1);
        chk("ov1_ov", 32'(bus.overrun), 32'd0);
        send_frame(8'h22, 1'b1);
        repeat (20) @(negedge clk);
        chk("ov2_data", 32'(bus.rx_data), 32'h22);
        chk("ov2_rda", 32'(bus.rda), 32'd1);
        chk("ov2_ov", 32'(bus.overrun), 32'd1);
        chk("ov2_fe", 32'(bus.framing_err), 32'd0);
        read_pulse();
        chk("ov_read_rda", 32'(bus.rda), 32'd0);
        chk("ov_read_ov", 32'(bus.overrun), 32'd0);
        chk("ov_read_fe", 32'(bus.framing_err), 32'd0);
        chk("ov_read_data", 32'(bus.rx_data), 32'h22);
        repeat (100) @(negedge clk);

        // Coincident read: 0x11 pending, rx_read on the edge 0x55 completes
        // (1520 clk after rx_busy rises).
        send_frame(8'h11, 1'b1);
        repeat (20) @(negedge clk);
        chk("co_pending_rda", 32'(bus.rda), 32'd1);
        fork
            send_frame(8'h55, 1'b1);
            begin
                wait_busy(busy_cyc);
                n = 0;
                while (cyc < busy_cyc + 1519 && n < 2000) begin
                    @(negedge clk);
                    n++;
                end
                bus.rx_read = 1'b1;
                @(negedge clk);
                bus.rx_read = 1'b0;
                chk("co_rda", 32'(bus.rda), 32'd1);
                chk("co_data", 32'(bus.rx_data), 32'h55);
                chk("co_ov", 32'(bus.overrun), 32'd0);
                chk("co_fe", 32'(bus.framing_err), 32'd0);
            end
        join
        read_pulse();
        chk("co_read_rda", 32'(bus.rda), 32'd0);
        repeat (100) @(negedge clk);

        // Reset during data bit 3 of 0xF0.
        fork
            send_frame(8'hF0, 1'b1);
            begin
                repeat (4 * BIT_CLK + 80) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                chk("mid_rst_data", 32'(bus.rx_data), 32'h00);
                chk("mid_rst_rda", 32'(bus.rda), 32'd0);
                chk("mid_rst_fe", 32'(bus.framing_err), 32'd0);
                chk("mid_rst_ov", 32'(bus.overrun), 32'd0);
                chk("mid_rst_busy", 32'(bus.rx_busy), 32'd0);
            end
        join
        repeat (320) @(negedge clk);
        chk("mid_rst_no_byte", 32'(bus.rda), 32'd0);
        send_frame(8'h0F, 1'b1);
        repeat (20) @(negedge clk);
        chk("0f_data", 32'(bus.rx_data), 32'h0F);
        chk("0f_rda", 32'(bus.rda), 32'd1);
        chk("0f_fe", 32'(bus.framing_err), 32'd0);
        chk("0f_ov", 32'(bus.overrun), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/spart_rx.md
Name: spart_rx

Overview:
- Receive half of the SPART; consumes the `rxEnable` oversample tick produced by the baud generator.
- Deserialises an 8N1 asynchronous frame from the `RxD` pin into a byte.
- Holds the byte and status flags for the bus interface, which reads the receive buffer at IOADDR 2'b00.
- Transmit side and bus decode are separate blocks.

Parameters:
- OVERSAMPLE, 16: `rxEnable` ticks per bit period; must be even and >= 4.
- DATA_BITS, 8: data bits per frame, LSB first.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- rxEnable  input  1  one-clk-wide pulse at OVERSAMPLE x baud rate, from baud generator.
- RxD  input  1  asynchronous serial input; idle high.
- rx_read  input  1  one-clk pulse from bus decode (IOCS & IORW & IOADDR==2'b00); consumes the buffer.
- rx_data  output  DATA_BITS  last received byte.
- rda  output  1  receive data available.
- framing_err  output  1  stop bit of the last byte sampled low.
- overrun  output  1  a byte completed while rda was already 1.
- rx_busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset: on rst high at a clk edge:
  - FSM goes to IDLE.
  - rx_data=0, rda=0, framing_err=0, overrun=0, rx_busy=0.
  - Synchroniser flops and shift register are set to 1; tick counter and bit counter are set to 0.
  - Reset mid-frame abandons the frame; no partial byte is ever loaded.
- Synchroniser: RxD passes through 2 flops (rxd_s). All sampling uses rxd_s, giving 2 clk of input latency.
- FSM advances only on clk edges where rxEnable=1. Between ticks all state holds.
- IDLE:
  - On a tick with rxd_s=0, go to START with tick_cnt=0.
  - Otherwise stay in IDLE.
- START:
  - tick_cnt increments each tick.
  - On the tick where tick_cnt reaches OVERSAMPLE/2-1 (the 8th tick for 16), sample rxd_s:
    - If 0, go to DATA with tick_cnt=0 and bit_cnt=0.
    - If 1, treat as a glitch and return to IDLE with no flag change.
- DATA:
  - tick_cnt counts 0..OVERSAMPLE-1.
  - On the tick where tick_cnt==OVERSAMPLE-1 (bit centre), shift rxd_s into the MSB of the shift register, shifting right so the LSB arrives first. Then set tick_cnt=0 and bit_cnt++.
  - After DATA_BITS samples, go to STOP.
- STOP:
  - Sample rxd_s at tick_cnt==OVERSAMPLE-1, then go to IDLE on the same edge.
  - On that edge, the shift register loads into rx_data, rda is set, and framing_err is set to the inverse of the sampled stop bit.
  - The byte is loaded even when framing_err=1.
  - Returning to IDLE at mid-stop-bit lets back-to-back frames be received.
- Latency: rda rises on the clk edge of the rxEnable tick at the stop-bit centre, about 9.5 bit times after the start-bit falling edge, plus synchroniser delay.
- Overrun:
  - If a byte completes while rda=1 and rx_read=0, set overrun=1 and overwrite rx_data; rda stays 1.
- rx_read:
  - On the next edge, clears rda, overrun and framing_err. rx_data holds its value.
  - rx_read while rda=0 has no effect.
- Read coincident with completion: completion wins.
  - rda=1, rx_data is the new byte, framing_err comes from the new stop bit, overrun=0.
  - The old byte is considered consumed.
- rx_busy = (state != IDLE), registered with the state.
- Counters are wide enough for their ranges and never wrap within a frame.

Test Plan:
- Byte 0xA5: clk 10 ns, rxEnable every 10 clk. Send 0xA5 8N1 at 160 clk/bit. Required: rda=1 with rx_data=8'hA5, framing_err=0, overrun=0; rda rises at the stop-bit-centre tick.
- Glitch rejection: RxD low for 4 ticks, then high. Required: FSM returns to IDLE after tick 8; rda stays 0; rx_busy pulses then drops. A following 0x3C frame is received correctly.
- Framing error: send 0x81 with the stop bit held low. Required: rx_data=8'h81, rda=1, framing_err=1. Then pulse rx_read: required rda=0, framing_err=0, rx_data still 8'h81.
- Overrun: send 0x11 then 0x22 back-to-back with no read. Required: after the 2nd frame, rx_data=8'h22, rda=1, overrun=1. After rx_read, all flags are 0.
- Coincident read: with 0x11 pending, assert rx_read on the exact edge 0x55 completes. Required: rda=1, rx_data=8'h55, overrun=0.
- Reset mid-frame: assert rst for 1 clk during data bit 3 of 0xF0. Required: all outputs 0, state IDLE. The next full frame 0x0F is received as 8'h0F with no flags set.
